// File: rtl/fifo_rd_packer.sv
// Drains 4-bit words from a show-ahead FIFO and packs RATIO of them into one wide
// valid/ready beat; flush emits a partial beat with a lane-keep mask.
module fifo_rd_packer #(
  parameter int unsigned DWIDTH = 4,
  parameter int unsigned RATIO  = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [DWIDTH-1:0]        fifo_q_i,
  input  logic                     fifo_empty_i,
  output logic                     fifo_rdreq_o,
  input  logic                     flush_i,
  output logic [DWIDTH*RATIO-1:0]  data_o,
  output logic [RATIO-1:0]         keep_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o
);

  localparam int unsigned CW = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int unsigned BW = DWIDTH * RATIO;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [RATIO-1:0][DWIDTH-1:0] acc_q, acc_n;
  logic [CW-1:0]                cnt_q, cnt_n;
  logic                         flush_pend_q, flush_pend_n;
  logic [BW-1:0]                data_q, data_n;
  logic [RATIO-1:0]             keep_q, keep_n;
  logic                         valid_q, valid_n;
  logic                         busy_q, busy_n;

  logic                         slot_free;
  logic                         rd_ok;
  logic [RATIO-1:0][DWIDTH-1:0] beat;

  // Read acknowledge: the last lane is only taken when the output slot can accept the beat
  always_comb begin
    slot_free = ~valid_q | ready_i;
    rd_ok     = arst_n_i & ~fifo_empty_i & ~flush_i & ~flush_pend_q
              & ~((cnt_q == LAST) & ~slot_free);
  end

  assign fifo_rdreq_o = rd_ok;

  // Next-state for accumulator, lane count, flush flag and output register
  always_comb begin
    acc_n        = acc_q;
    cnt_n        = cnt_q;
    flush_pend_n = flush_pend_q;
    data_n       = data_q;
    keep_n       = keep_q;
    valid_n      = valid_q;
    beat         = acc_q;

    if (valid_q && ready_i) begin
      valid_n = 1'b0;
    end

    if (rd_ok) begin
      if (cnt_q == LAST) begin
        beat[RATIO-1] = fifo_q_i;
        data_n        = beat;
        keep_n        = '1;
        valid_n       = 1'b1;
        cnt_n         = '0;
        acc_n         = '0;
      end else begin
        acc_n[cnt_q] = fifo_q_i;
        cnt_n        = cnt_q + CW'(1);
      end
    end

    // Reads are blocked while pending, so rd_ok and a flush load never coincide
    if (flush_pend_q) begin
      if (cnt_q == '0) begin
        flush_pend_n = 1'b0;
      end else if (slot_free) begin
        for (int k = 0; k < int'(RATIO); k++) begin
          if (CW'(k) < cnt_q) begin
            beat[k]   = acc_q[k];
            keep_n[k] = 1'b1;
          end else begin
            beat[k]   = '0;
            keep_n[k] = 1'b0;
          end
        end
        data_n       = beat;
        valid_n      = 1'b1;
        cnt_n        = '0;
        acc_n        = '0;
        flush_pend_n = 1'b0;
      end
    end else if (flush_i) begin
      flush_pend_n = 1'b1;
    end

    busy_n = (cnt_n != '0) | flush_pend_n;
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      acc_q        <= acc_n;
      cnt_q        <= cnt_n;
      flush_pend_q <= flush_pend_n;
      data_q       <= data_n;
      keep_q       <= keep_n;
      valid_q      <= valid_n;
      busy_q       <= busy_n;
    end
  end

  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model feeds words, a scoreboard queue holds the
// expected word stream and a monitor unpacks every transferred beat against it.
module tb_fifo_rd_packer;

  logic        clk;
  logic        arst_n_i;
  logic [3:0]  fifo_q_i;
  logic        fifo_empty_i;
  logic        fifo_rdreq_o;
  logic        flush_i;
  logic [15:0] data_o;
  logic [3:0]  keep_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;

  fifo_rd_packer #(.DWIDTH(4), .RATIO(4)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .flush_i      (flush_i),
    .data_o       (data_o),
    .keep_o       (keep_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] fifo_m[$];
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Writing into the FIFO model is the stimulus; the word joins the expected stream
  task automatic fifo_write(input logic [3:0] w);
    fifo_m.push_back(w);
    exp_q.push_back(w);
  endtask

  // One cycle, entered and left on a falling edge; sampled just before the rising edge
  task automatic step(input logic fl, input logic rd, output logic rq);
    flush_i      = fl;
    ready_i      = rd;
    fifo_empty_i = (fifo_m.size() == 0);
    fifo_q_i     = fifo_empty_i ? 4'h0 : fifo_m[0];
    #4;
    rq = fifo_rdreq_o;
    if (rq) begin
      chk("rdreq_while_empty", 32'(fifo_empty_i), 32'd0);
      if (fifo_m.size() != 0) void'(fifo_m.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic wait_beat(input string name, input int maxc);
    logic rq;
    int i;
    i = 0;
    while (!valid_o && i < maxc) begin
      step(1'b0, 1'b1, rq);
      i++;
    end
    chk({name, "_beat_seen"}, 32'(valid_o), 32'd1);
  endtask

  // Monitor: unpack each transferred beat and check held beats under backpressure
  initial begin : monitor
    logic        stall;
    logic [15:0] pd;
    logic [3:0]  pk;
    logic [15:0] expd;
    int          n;
    stall = 1'b0;
    pd    = '0;
    pk    = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!arst_n_i) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 32'(valid_o), 32'd1);
          chk("hold_beat", {12'h0, keep_o, data_o}, {12'h0, pk, pd});
        end
        if (valid_o && ready_i) begin
          n = 0;
          for (int k = 0; k < 4; k++) if (keep_o[k]) n++;
          chk("keep_nonzero", 32'(keep_o != 4'h0), 32'd1);
          chk("keep_shape", 32'(keep_o), 32'((1 << n) - 1));
          expd = '0;
          for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_word", 32'd1, 32'd0);
            end else begin
              expd[k*4 +: 4] = exp_q.pop_front();
            end
          end
          chk("beat_data", 32'(data_o), 32'(expd));
        end
        stall = valid_o & ~ready_i;
        pd    = data_o;
        pk    = keep_o;
      end
    end
  end

  initial begin : main
    logic rq;
    int   nrd;
    int   written;
    arst_n_i     = 1'b0;
    flush_i      = 1'b0;
    ready_i      = 1'b1;
    fifo_empty_i = 1'b1;
    fifo_q_i     = 4'h0;

    // Reset values, rdreq gated by reset even with a non-empty FIFO
    @(negedge clk);
    for (int w = 1; w <= 4; w++) fifo_write(4'(w));
    fifo_empty_i = 1'b0;
    fifo_q_i     = 4'h1;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_keep", 32'(keep_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rdreq", 32'(fifo_rdreq_o), 32'd0);
    @(negedge clk);
    arst_n_i = 1'b1;

    // Full beat 1,2,3,4 with ready high
    nrd = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, rq);
      nrd += int'(rq);
    end
    chk("t1_rdreq_cycles", 32'(nrd), 32'd4);
    chk("t1_valid", 32'(valid_o), 32'd1);
    chk("t1_data", 32'(data_o), 32'h4321);
    chk("t1_keep", 32'(keep_o), 32'hF);
    step(1'b0, 1'b1, rq);
    chk("t1_valid_one_cycle", 32'(valid_o), 32'd0);

    // Backpressure: 7 words absorbed, 8th waits for ready
    for (int w = 1; w <= 8; w++) fifo_write(4'(w));
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, rq);
      nrd += int'(rq);
    end
    chk("t2_rdreq_cycles", 32'(nrd), 32'd7);
    chk("t2_held_valid", 32'(valid_o), 32'd1);
    chk("t2_held_data", 32'(data_o), 32'h4321);
    step(1'b0, 1'b1, rq);
    chk("t2_rdreq_on_ready", 32'(rq), 32'd1);
    chk("t2_b2b_valid", 32'(valid_o), 32'd1);
    chk("t2_b2b_data", 32'(data_o), 32'h8765);
    step(1'b0, 1'b1, rq);
    chk("t2_drained", 32'(valid_o), 32'd0);

    // Partial flush A,B; a word present during the flush cycle stays in the FIFO
    fifo_write(4'hA);
    fifo_write(4'hB);
    step(1'b0, 1'b1, rq);
    step(1'b0, 1'b1, rq);
    fifo_write(4'hC);
    step(1'b1, 1'b1, rq);
    chk("t3_no_read_on_flush", 32'(rq), 32'd0);
    step(1'b0, 1'b1, rq);
    chk("t3_no_read_pending", 32'(rq), 32'd0);
    chk("t3_valid", 32'(valid_o), 32'd1);
    chk("t3_data", 32'(data_o), 32'h00BA);
    chk("t3_keep", 32'(keep_o), 32'h3);
    fifo_write(4'hD);
    fifo_write(4'hE);
    fifo_write(4'hF);
    step(1'b0, 1'b1, rq);
    wait_beat("t3", 8);
    chk("t3_full_data", 32'(data_o), 32'hFEDC);
    chk("t3_full_keep", 32'(keep_o), 32'hF);
    step(1'b0, 1'b1, rq);

    // Flush with nothing accumulated: busy for one cycle, no beat
    chk("t4_busy_before", 32'(busy_o), 32'd0);
    step(1'b1, 1'b1, rq);
    chk("t4_busy_pend", 32'(busy_o), 32'd1);
    chk("t4_no_valid_a", 32'(valid_o), 32'd0);
    step(1'b0, 1'b1, rq);
    chk("t4_busy_clear", 32'(busy_o), 32'd0);
    chk("t4_no_valid_b", 32'(valid_o), 32'd0);

    // Reset mid-beat discards the two accumulated words
    fifo_write(4'h1);
    fifo_write(4'h2);
    step(1'b0, 1'b1, rq);
    step(1'b0, 1'b1, rq);
    chk("t5_busy_mid", 32'(busy_o), 32'd1);
    arst_n_i = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid_o), 32'd0);
    chk("t5_rst_data", 32'(data_o), 32'd0);
    chk("t5_rst_keep", 32'(keep_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    fifo_m.delete();
    for (int w = 9; w <= 12; w++) fifo_write(4'(w));
    fifo_empty_i = 1'b0;
    fifo_q_i     = 4'h9;
    #1;
    chk("t5_rst_rdreq", 32'(fifo_rdreq_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n_i = 1'b1;
    wait_beat("t5", 8);
    chk("t5_data", 32'(data_o), 32'hCBA9);
    chk("t5_keep", 32'(keep_o), 32'hF);
    step(1'b0, 1'b1, rq);

    // Random traffic, backpressure and flushes
    written = 0;
    for (int c = 0; c < 20000 && written < 1000; c++) begin
      if ($urandom_range(0, 99) < 60) begin
        fifo_write(4'($urandom_range(0, 15)));
        written++;
      end
      step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)), rq);
    end
    chk("rand_all_written", 32'(written), 32'd1000);
    for (int c = 0; c < 2000 && fifo_m.size() != 0; c++) step(1'b0, 1'b1, rq);
    step(1'b0, 1'b1, rq);
    step(1'b1, 1'b1, rq);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rq);
    chk("rand_fifo_drained", 32'(fifo_m.size()), 32'd0);
    chk("rand_stream_complete", 32'(exp_q.size()), 32'd0);
    chk("rand_idle_valid", 32'(valid_o), 32'd0);
    chk("rand_idle_busy", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the show-ahead single-clock FIFO. It drains 4-bit words from the FIFO and packs RATIO consecutive words into one wide output beat. Beats leave on a valid/ready stream. A flush input forces a partially filled beat out, with a lane-keep mask. The block sits between the FIFO read port and a wide downstream datapath, and sustains one FIFO word per clock.

## Interface
- DWIDTH, 4, FIFO word width.
- RATIO, 4, words per output beat; integer, ≥ 2.
- clk_i  in  1  clock; all state changes on the rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- fifo_q_i  in  DWIDTH  FIFO show-ahead head word; valid whenever fifo_empty_i = 0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rdreq_o  out  1  read acknowledge: the head word is consumed at this edge.
- flush_i  in  1  single-cycle request to emit the current partial beat.
- data_o  out  DWIDTH*RATIO  output beat; lane k occupies bits [k*DWIDTH +: DWIDTH]; lane 0 holds the first word.
- keep_o  out  RATIO  lane-valid mask of the output beat.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accept; a beat transfers when valid_o & ready_i.
- busy_o  out  1  high when the accumulator count > 0 or flush is pending.

## Operation
- State:
  - accumulator acc (RATIO lanes);
  - lane count cnt, range 0..RATIO-1, width $clog2(RATIO);
  - flush_pend flag;
  - output register (data_o, keep_o, valid_o).
- slot_free = ~valid_o | ready_i.
- fifo_rdreq_o = arst_n_i & ~fifo_empty_i & ~flush_i & ~flush_pend & ~(cnt == RATIO-1 & ~slot_free).
- fifo_rdreq_o is combinational from inputs and state, and is never asserted while fifo_empty_i = 1.
- On a consumed word:
  - acc[cnt] <= fifo_q_i.
  - If cnt < RATIO-1: cnt increments.
  - If cnt == RATIO-1: the full beat {fifo_q_i, acc[RATIO-2:0]} loads the output register with keep_o = all ones and valid_o = 1. cnt wraps to 0 and acc clears.
- Flush:
  - flush_i sets flush_pend. Word reads are blocked from the cycle flush_i is high.
  - While flush_pend is set and cnt > 0 and slot_free: the output register loads acc, with keep_o bit k = (k < cnt) and unused lanes zero. cnt <= 0, acc clears, flush_pend clears.
  - If cnt == 0, flush_pend clears on the next edge and no beat is produced.
  - flush_i while flush_pend is already set has no additional effect.
- Output register:
  - It holds its value while valid_o & ~ready_i.
  - On a transfer with no new beat loading, valid_o <= 0. data_o and keep_o hold their last value.
  - A new beat may load in the same cycle the previous beat transfers, giving back-to-back beats.
- Ordering: words appear on data_o in exact FIFO order. No word is dropped or duplicated, including across flushes.

## Timing
- Reset values: valid_o = 0, data_o = 0, keep_o = 0, busy_o = 0, cnt = 0, flush_pend = 0. fifo_rdreq_o = 0 while arst_n_i is low.
- Reset asserted mid-beat discards acc and the output register immediately. Words already consumed are lost; this is by design.
- Latency: valid_o rises on the edge that consumes the RATIO-th word, i.e. it is visible in the cycle after that rdreq.
- Flush latency: partial beat valid 2 edges after flush_i when the output slot is free.
- Throughput: 1 word per cycle with ready_i held high; a full beat every RATIO cycles with no bubbles.
- Backpressure: with valid_o & ~ready_i, up to RATIO-1 further words are absorbed. The RATIO-th word is not read until ready_i rises; rdreq then reasserts combinationally in that same cycle.
- flush_i and fifo_empty_i = 0 in the same cycle: the word is NOT consumed that cycle.

## Test plan
- DWIDTH=4, RATIO=4; FIFO fed 1,2,3,4 with ready_i=1 -> rdreq high 4 cycles, then data_o = 16'h4321, keep_o = 4'hF, valid_o for exactly 1 cycle.
- ready_i=0, 8 words 1..8 written -> beat 16'h4321 held. rdreq stops after word 7 (cnt=3). On ready_i=1: 16'h4321, then 16'h8765 on the next cycle.
- Words A,B then flush_i pulse -> data_o = 16'h00BA, keep_o = 4'b0011. The next 4 words form a full beat with keep 4'hF.
- flush_i with cnt=0 and FIFO empty -> no valid_o; busy_o high for one cycle only.
- arst_n_i pulsed low after 2 words -> all outputs at reset values during reset. The subsequent 4 words form a correct beat with no stale lanes.
- Random: 1000 random words through the FIFO model, random ready_i (50%), random flush (2%) -> unpacked stream (keep-masked lanes) equals the input sequence exactly, with no valid_o drop while ~ready_i.
